// File: rtl/flash_read_responder.sv
// Avalon-MM pipelined-read responder standing in for the flash controller.
// Optional stat_reads/stat_stalls counters under FLASH_READ_RESPONDER_STATS_EN.
module flash_read_responder #(
    parameter int ADDR_W       = 23,
    parameter int WAIT_STATES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flsh_read,
    input  logic [ADDR_W-1:0] flsh_address,
    input  logic [3:0]        flsh_byteenable,
    output logic              flsh_waitrequest,
    output logic [31:0]       flsh_readdata,
    output logic              flsh_readdatavalid
`ifdef FLASH_READ_RESPONDER_STATS_EN
    ,
    output logic [15:0]       stat_reads,
    output logic [15:0]       stat_stalls
`endif
);

    localparam int              PW   = (MAX_PENDING < 1) ? 1 : $clog2(MAX_PENDING + 1);
    localparam logic [3:0]      WS   = 4'(WAIT_STATES);
    localparam logic [PW-1:0]   MAXP = PW'(MAX_PENDING);

    logic [3:0]              wait_cnt;
    logic [PW-1:0]           pending;
    logic [READ_LATENCY-1:0] vld;
    logic [READ_LATENCY-1:0] vld_in;
    logic [31:0]             data [READ_LATENCY];
    logic                    accept;
    logic                    ret_next;
    logic [15:0]             a16;
    logic [31:0]             word;

    generate
        if (ADDR_W >= 16) begin : g_addr_trunc
            assign a16 = flsh_address[15:0];
            if (ADDR_W > 16) begin : g_addr_hi
                logic unused_addr_hi;
                assign unused_addr_hi = ^flsh_address[ADDR_W-1:16];
            end
        end else begin : g_addr_ext
            assign a16 = {{(16-ADDR_W){1'b0}}, flsh_address};
        end
    endgenerate

    // A slot counts as freed on the edge a word enters the output stage, so a
    // stalled read at the full boundary is accepted in the cycle that word returns.
    always_comb begin
        flsh_waitrequest = flsh_read && ((wait_cnt != WS) || (pending == MAXP));
        accept           = flsh_read && !flsh_waitrequest;
        word             = {a16, ~a16} & {{8{flsh_byteenable[3]}}, {8{flsh_byteenable[2]}},
                                          {8{flsh_byteenable[1]}}, {8{flsh_byteenable[0]}}};
        vld_in           = '0;
        vld_in[0]        = accept;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld_in[i] = vld[i-1];
        end
        ret_next         = vld_in[READ_LATENCY-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!flsh_read || accept) begin
            wait_cnt <= '0;
        end else if (wait_cnt < WS) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (accept && !ret_next) begin
            pending <= pending + PW'(1);
        end else if (!accept && ret_next) begin
            pending <= pending - PW'(1);
        end
    end

    // Data stages advance only behind a valid word, so the last stage holds
    // the most recent return while readdatavalid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data[i] <= '0;
            end
        end else begin
            vld <= vld_in;
            if (accept) begin
                data[0] <= word;
            end
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                if (vld[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
        end
    end

    assign flsh_readdatavalid = vld[READ_LATENCY-1];
    assign flsh_readdata      = data[READ_LATENCY-1];

`ifdef FLASH_READ_RESPONDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_reads  <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept && stat_reads != '1) begin
                stat_reads <= stat_reads + 16'd1;
            end
            if (flsh_read && flsh_waitrequest && stat_stalls != '1) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_flash_read_responder.sv
// Directed bench for flash_read_responder: default instance plus a zero-wait-state instance.
module tb_flash_read_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_a, wr_a, rdv_a;
    logic [22:0] addr_a;
    logic [3:0]  be_a;
    logic [31:0] data_a;
    logic        rd_b, wr_b, rdv_b;
    logic [22:0] addr_b;
    logic [3:0]  be_b;
    logic [31:0] data_b;
`ifdef FLASH_READ_RESPONDER_STATS_EN
    logic [15:0] sr_a, ss_a, sr_b, ss_b;
`endif
    int checks = 0;
    int errors = 0;
    int rdv_cnt_a = 0;
    int base;

    always #5 clk = ~clk;

    flash_read_responder dut_a (
        .clk                (clk),
        .rst                (rst),
        .flsh_read          (rd_a),
        .flsh_address       (addr_a),
        .flsh_byteenable    (be_a),
        .flsh_waitrequest   (wr_a),
        .flsh_readdata      (data_a),
        .flsh_readdatavalid (rdv_a)
`ifdef FLASH_READ_RESPONDER_STATS_EN
        ,
        .stat_reads         (sr_a),
        .stat_stalls        (ss_a)
`endif
    );

    flash_read_responder #(
        .ADDR_W       (23),
        .WAIT_STATES  (0),
        .READ_LATENCY (3),
        .MAX_PENDING  (2)
    ) dut_b (
        .clk                (clk),
        .rst                (rst),
        .flsh_read          (rd_b),
        .flsh_address       (addr_b),
        .flsh_byteenable    (be_b),
        .flsh_waitrequest   (wr_b),
        .flsh_readdata      (data_b),
        .flsh_readdatavalid (rdv_b)
`ifdef FLASH_READ_RESPONDER_STATS_EN
        ,
        .stat_reads         (sr_b),
        .stat_stalls        (ss_b)
`endif
    );

    always @(negedge clk) if (rdv_a === 1'b1) rdv_cnt_a++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; runs one read on dut_a end to end.
    task automatic read_a(input string tag, input logic [22:0] a, input logic [3:0] b,
                          input logic [31:0] exp_word, input int exp_waits);
        int waits;
        int lat;
        rd_a = 1'b1; addr_a = a; be_a = b;
        #1;
        waits = 0;
        while (wr_a && waits < 20) begin
            tick(); #1; waits++;
        end
        check({tag, " waits"}, 32'(waits), 32'(exp_waits));
        tick();
        rd_a = 1'b0;
        #1;
        lat = 1;
        while (!rdv_a && lat < 16) begin
            tick(); #1; lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " data"}, data_a, exp_word);
        tick(); #1;
        check({tag, " rdv drop"}, 32'(rdv_a), 32'd0);
        check({tag, " data hold"}, data_a, exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rd_a = 1'b0; addr_a = '0; be_a = '0;
        rd_b = 1'b0; addr_b = '0; be_b = '0;
        tick(); tick(); #1;
        check("reset rdv", 32'(rdv_a), 32'd0);
        check("reset data", data_a, 32'h0);
        check("reset wr idle", 32'(wr_a), 32'd0);
        rst = 1'b0;

        // Default timing, cycle by cycle.
        tick();
        rd_a = 1'b1; addr_a = 23'h10; be_a = 4'hF;
        #1; check("t1 wr c0", 32'(wr_a), 32'd1);
        tick(); #1; check("t1 wr c1", 32'(wr_a), 32'd1);
        tick(); #1; check("t1 wr c2", 32'(wr_a), 32'd0);
        tick(); rd_a = 1'b0;
        #1; check("t1 rdv c3", 32'(rdv_a), 32'd0);
        tick(); #1; check("t1 rdv c4", 32'(rdv_a), 32'd0);
        tick(); #1; check("t1 rdv c5", 32'(rdv_a), 32'd1);
        check("t1 data c5", data_a, 32'h0010FFEF);
        tick(); #1; check("t1 rdv c6", 32'(rdv_a), 32'd0);
        check("t1 data c6", data_a, 32'h0010FFEF);

        // Byte lane masking.
        tick(); read_a("be3", 23'h0000AB, 4'h3, 32'h0000FF54, 2);
        tick(); read_a("beC", 23'h0000AB, 4'hC, 32'h00AB0000, 2);
`ifdef FLASH_READ_RESPONDER_STATS_EN
        check("stat_reads", 32'(sr_a), 32'd3);
        check("stat_stalls", 32'(ss_a), 32'd6);
`endif
        tick(); read_a("be5", 23'h001234, 4'h5, 32'h003400CB, 2);
        tick(); read_a("addr hi", 23'h7F5A5A, 4'hF, 32'h5A5AA5A5, 2);

        // Abandoned read: no response, fresh wait count on re-assert.
        tick();
        base = rdv_cnt_a;
        rd_a = 1'b1; addr_a = 23'h55; be_a = 4'hF;
        #1; check("abandon wr", 32'(wr_a), 32'd1);
        tick(); rd_a = 1'b0;
        #1; check("abandon wr idle", 32'(wr_a), 32'd0);
        tick();
        tick(); read_a("reassert", 23'h000055, 4'hF, 32'h0055FFAA, 2);
        repeat (6) tick();
        check("abandon one rdv", 32'(rdv_cnt_a - base), 32'd1);

        // Reset one cycle after acceptance discards the read.
        tick();
        rd_a = 1'b1; addr_a = 23'h20; be_a = 4'hF;
        #1;
        for (int i = 0; i < 20 && wr_a; i++) begin
            tick(); #1;
        end
        tick(); rd_a = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        #1;
        check("rst rdv", 32'(rdv_a), 32'd0);
        check("rst data", data_a, 32'h0);
        base = rdv_cnt_a;
        repeat (8) tick();
        check("rst no rdv", 32'(rdv_cnt_a - base), 32'd0);
        tick(); read_a("post rst", 23'h000020, 4'hF, 32'h0020FFDF, 2);

        // Read held across a reset restarts its wait count.
        tick();
        rd_a = 1'b1; addr_a = 23'h30; be_a = 4'hF;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        read_a("held rst", 23'h000030, 4'hF, 32'h0030FFCF, 2);

        // Zero wait states, pending limit reached and released on return.
        tick();
        rd_b = 1'b1; addr_b = 23'd1; be_b = 4'hF;
        #1; check("ws0 wr c0", 32'(wr_b), 32'd0);
        tick(); addr_b = 23'd2;
        #1; check("ws0 wr c1", 32'(wr_b), 32'd0);
        tick(); addr_b = 23'd3;
        #1; check("ws0 wr c2", 32'(wr_b), 32'd1);
        check("ws0 rdv c2", 32'(rdv_b), 32'd0);
        tick(); #1;
        check("ws0 wr c3", 32'(wr_b), 32'd0);
        check("ws0 rdv c3", 32'(rdv_b), 32'd1);
        check("ws0 data c3", data_b, 32'h0001FFFE);
        tick(); rd_b = 1'b0;
        #1; check("ws0 rdv c4", 32'(rdv_b), 32'd1);
        check("ws0 data c4", data_b, 32'h0002FFFD);
        tick(); #1; check("ws0 rdv c5", 32'(rdv_b), 32'd0);
        check("ws0 data c5", data_b, 32'h0002FFFD);
        tick(); #1; check("ws0 rdv c6", 32'(rdv_b), 32'd1);
        check("ws0 data c6", data_b, 32'h0003FFFC);
        tick(); #1; check("ws0 rdv c7", 32'(rdv_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flash_read_responder.md
Name: flash_read_responder

Overview:
- Avalon-MM pipelined-read slave that models the flash controller side of the flash read interface. It is the responder for the flash reader master.
- Inserts a configurable number of wait states per read and returns data a fixed latency after acceptance, with a bounded number of reads outstanding.
- Serves a deterministic, address-derived 32-bit data pattern so that simulation and bring-up benches can self-check audio sample fetches without a real flash part.

Parameters:
- ADDR_W, 23, width of the word address.
- WAIT_STATES, 2, number of cycles waitrequest is held high on each read before acceptance (0..15).
- READ_LATENCY, 3, cycles from the acceptance edge to readdatavalid (1..8).
- MAX_PENDING, 2, maximum accepted-but-unreturned reads (1..READ_LATENCY).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- flsh_read  in  1  read request from the master.
- flsh_address  in  ADDR_W  word address, valid while flsh_read is high.
- flsh_byteenable  in  4  byte-lane mask, sampled at acceptance.
- flsh_waitrequest  out  1  stall; the request is accepted on a cycle with flsh_read=1 and flsh_waitrequest=0.
- flsh_readdata  out  32  returned word.
- flsh_readdatavalid  out  1  one-cycle strobe per returned word.

Behaviour:
- Reset (async assert, sync release):
  - wait counter = 0, pending count = 0, latency pipeline valid bits cleared.
  - flsh_readdatavalid = 0, flsh_readdata = 32'h0.
- flsh_waitrequest (combinational) = flsh_read && (wait_cnt != WAIT_STATES || pending == MAX_PENDING). It is 0 whenever flsh_read=0.
- Wait counter:
  - Increments on each cycle with flsh_read=1 and wait_cnt < WAIT_STATES.
  - Clears to 0 on acceptance.
  - Clears to 0 if flsh_read drops before acceptance (master abandon; no response is generated).
  - Saturates at WAIT_STATES while stalled on pending == MAX_PENDING.
- Acceptance:
  - Captures address and byteenable into stage 0 of a READ_LATENCY-deep valid/data shift pipeline.
  - Pending count increments.
  - With WAIT_STATES=0 and pending < MAX_PENDING, a read is accepted in the cycle it is first asserted, and back-to-back accepts every cycle are allowed.
- Return:
  - The pipeline output registers drive flsh_readdatavalid=1 exactly READ_LATENCY cycles after the acceptance edge, for one cycle.
  - Pending count decrements on that cycle.
  - Returns are strictly in acceptance order.
- Simultaneous accept and return in the same cycle: pending count is unchanged, so a read at the full boundary is accepted in the same cycle a slot frees.
- Data pattern: word = {addr[15:0], ~addr[15:0]}, with addr zero-extended if ADDR_W < 16. Byte lane i is forced to 8'h00 when byteenable[i]=0 at acceptance.
- flsh_readdata holds the last returned word while flsh_readdatavalid=0.
- Reset mid-operation: all in-flight reads are discarded and no readdatavalid follows. A read still asserted after reset release restarts its wait-state count from 0.
- Address/byteenable changes during wait states are ignored; only the values present on the acceptance cycle are used.

Optional Feature:
- Macro FLASH_READ_RESPONDER_STATS_EN.
- Defined:
  - Adds outputs stat_reads (16, count of acceptances) and stat_stalls (16, count of cycles with flsh_read=1 and flsh_waitrequest=1).
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent; the behaviour of all other ports is identical.

Test Plan:
- Defaults. flsh_read=1, address 0x000010, byteenable 4'hF from cycle 0.
  - waitrequest high cycles 0-1, low cycle 2 (accept).
  - readdatavalid high only in cycle 5, readdata=32'h0010FFEF, then held.
- Byteenable 4'h3, address 0x0000AB.
  - Returned word 32'h0000FF54.
  - Byteenable 4'hC, same address: returned word 32'h00AB0000.
- WAIT_STATES=0, MAX_PENDING=2, READ_LATENCY=3, read held high with addresses 1,2,3.
  - Accepts in cycles 0,1; waitrequest high in cycle 2; accept in cycle 3 (simultaneous with the first return).
  - readdatavalid in cycles 3,4,6 with data 32'h0001FFFE, 32'h0002FFFD, 32'h0003FFFC.
- Read dropped after 1 wait cycle, re-asserted 2 cycles later: a full 2 fresh wait cycles are required, and exactly one readdatavalid results.
- rst pulsed 1 cycle after acceptance: no readdatavalid for the next 8 cycles. A subsequent read completes with the normal timing.
- STATS_EN build, 3 reads at the defaults: stat_reads=3, stat_stalls=6.
